// File: rtl/sign_narrow_saturator_pkg.sv
// Shared narrowing constants: default widths, mode encodings and the signed
// range limits of a narrow two's-complement word.
package alu_pkg;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 15;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    MODE_SAT  = 1'b0,
    MODE_WRAP = 1'b1
  } narrow_mode_e;

  // Largest positive value of an out_w-bit signed word, zero-padded to 32 bits.
  function automatic logic [31:0] sat_max(input int out_w);
    return 32'((64'd1 << (out_w - 1)) - 64'd1);
  endfunction

  // Bit pattern of the most negative out_w-bit signed word (sign bit only).
  function automatic logic [31:0] sat_min(input int out_w);
    return 32'(64'd1 << (out_w - 1));
  endfunction

endpackage

// File: rtl/sign_narrow_saturator_core.sv
// Combinational narrowing of one wide two's-complement value: detects whether
// it fits in OUT_W bits and either clamps or truncates when it does not.
module sat_narrow_core
  import alu_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_mode,
  output logic [OUT_W-1:0] out_data,
  output logic             ovf
);

  localparam logic [31:0] MAX_WIDE = sat_max(OUT_W);
  localparam logic [31:0] MIN_WIDE = sat_min(OUT_W);

  logic [OUT_W-1:0]    max_val;
  logic [OUT_W-1:0]    min_val;
  logic [IN_W-OUT_W:0] upper;
  logic                fit;

  assign max_val = MAX_WIDE[OUT_W-1:0];
  assign min_val = MIN_WIDE[OUT_W-1:0];

  // The value fits when every bit from the narrow sign bit upward agrees.
  assign upper = in_data[IN_W-1:OUT_W-1];
  assign fit   = (&upper) | ~(|upper);
  assign ovf   = ~fit;

  always_comb begin
    out_data = in_data[OUT_W-1:0];
    if (ovf && (in_mode == MODE_SAT)) begin
      out_data = in_data[IN_W-1] ? min_val : max_val;
    end
  end

endmodule

// File: rtl/sign_narrow_saturator.sv
// Streaming 32->15 bit narrower with an output register plus one skid entry,
// and overflow statistics updated when a beat is accepted.
module sign_narrow_saturator
  import alu_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clear_stats
);

  logic [OUT_W-1:0] core_data;
  logic             core_ovf;

  logic [OUT_W-1:0] out_data_reg,   out_data_next;
  logic             out_ovf_reg,    out_ovf_next;
  logic             out_valid_reg,  out_valid_next;
  logic [OUT_W-1:0] skid_data_reg,  skid_data_next;
  logic             skid_ovf_reg,   skid_ovf_next;
  logic             skid_valid_reg, skid_valid_next;
  logic [CNT_W-1:0] count_reg,      count_next;
  logic             sticky_reg,     sticky_next;

  logic accept;
  logic out_free;

  sat_narrow_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_data (core_data),
    .ovf      (core_ovf)
  );

  // Readiness depends only on stored state, never on out_ready.
  assign in_ready = ~skid_valid_reg & ~rst;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid_reg | out_ready;

  always_comb begin
    out_data_next   = out_data_reg;
    out_ovf_next    = out_ovf_reg;
    out_valid_next  = out_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_ovf_next   = skid_ovf_reg;
    skid_valid_next = skid_valid_reg;

    if (out_free) begin
      if (skid_valid_reg) begin
        // in_ready is low while skid is full, so no new beat competes here.
        out_data_next   = skid_data_reg;
        out_ovf_next    = skid_ovf_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        out_data_next  = core_data;
        out_ovf_next   = core_ovf;
        out_valid_next = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_data_next  = core_data;
      skid_ovf_next   = core_ovf;
      skid_valid_next = 1'b1;
    end
  end

  always_comb begin
    count_next  = count_reg;
    sticky_next = sticky_reg;
    if (accept && core_ovf) begin
      sticky_next = 1'b1;
      if (clear_stats) begin
        count_next = CNT_W'(1);
      end else if (~&count_reg) begin
        count_next = count_reg + CNT_W'(1);
      end
    end else if (clear_stats) begin
      count_next  = '0;
      sticky_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg   <= '0;
      out_ovf_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_ovf_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      count_reg      <= '0;
      sticky_reg     <= 1'b0;
    end else begin
      out_data_reg   <= out_data_next;
      out_ovf_reg    <= out_ovf_next;
      out_valid_reg  <= out_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_ovf_reg   <= skid_ovf_next;
      skid_valid_reg <= skid_valid_next;
      count_reg      <= count_next;
      sticky_reg     <= sticky_next;
    end
  end

  assign out_data   = out_data_reg;
  assign out_ovf    = out_ovf_reg;
  assign out_valid  = out_valid_reg;
  assign ovf_count  = count_reg;
  assign ovf_sticky = sticky_reg;

endmodule

// File: tb/tb_sign_narrow_saturator.sv
// Directed and randomized checks of the narrowing stream against an
// arithmetic reference model with an in-order scoreboard.
module tb_sign_narrow_saturator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_data;
  logic        out_ovf;
  logic        ovf_sticky;
  logic [15:0] ovf_count;
  logic        clear_stats;

  sign_narrow_saturator dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .ovf_sticky  (ovf_sticky),
    .ovf_count   (ovf_count),
    .clear_stats (clear_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] data;
    logic        ovf;
  } beat_t;

  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_count = 16'd0;
  logic        m_sticky = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: treat the input as a signed integer and compare with the 15-bit range.
  function automatic beat_t ref_narrow(input logic [31:0] d, input logic m);
    beat_t  b;
    longint v;
    v = longint'($signed(d));
    b.ovf = (v > 64'sd16383) || (v < -64'sd16384);
    if (b.ovf && !m) b.data = (v > 0) ? 15'h3FFF : 15'h4000;
    else             b.data = d[14:0];
    return b;
  endfunction

  // One cycle: drive at negedge, score the output transfer and acceptance,
  // then advance to the next negedge and compare the statistics.
  task automatic step(input logic v, input logic [31:0] d, input logic m,
                      input logic r, input logic c, output logic acc);
    beat_t e;
    beat_t n;
    in_valid = v; in_data = d; in_mode = m; out_ready = r; clear_stats = c;
    acc = v && in_ready;
    if (out_valid && r) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_ovf", 64'(out_ovf), 64'(e.ovf));
      end
    end
    n = ref_narrow(d, m);
    if (acc) exp_q.push_back(n);
    if (acc && n.ovf) begin
      m_sticky = 1'b1;
      if (c) m_count = 16'd1;
      else if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    end else if (c) begin
      m_count = 16'd0;
      m_sticky = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("ovf_count", 64'(ovf_count), 64'(m_count));
    check("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
    in_valid = 1'b0;
    clear_stats = 1'b0;
  endtask

  initial begin
    logic        acc;
    logic [31:0] x;
    logic [31:0] b[4];
    int          sent;
    int          budget;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
    out_ready = 1'b0; clear_stats = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_count", 64'(ovf_count), 64'd0);
    rst = 1'b0;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Values that fit pass through unchanged.
    step(1'b1, 32'h0000_1234, 1'b0, 1'b1, 1'b0, acc);
    check("fit_pos_data", 64'(out_data), 64'h1234);
    check("fit_pos_ovf", 64'(out_ovf), 64'd0);
    step(1'b1, 32'hFFFF_C000, 1'b0, 1'b1, 1'b0, acc);
    check("fit_neg_data", 64'(out_data), 64'h4000);
    check("fit_neg_ovf", 64'(out_ovf), 64'd0);

    // Saturation at both ends.
    step(1'b1, 32'h0000_4000, 1'b0, 1'b1, 1'b0, acc);
    check("sat_max_data", 64'(out_data), 64'h3FFF);
    check("sat_max_ovf", 64'(out_ovf), 64'd1);
    step(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, acc);
    check("sat_min_data", 64'(out_data), 64'h4000);
    check("sat_min_ovf", 64'(out_ovf), 64'd1);
    check("sat_count", 64'(ovf_count), 64'd2);
    check("sat_sticky", 64'(ovf_sticky), 64'd1);

    // Wrap mode truncates even on overflow.
    step(1'b1, 32'h0001_2345, 1'b1, 1'b1, 1'b0, acc);
    check("wrap_a_data", 64'(out_data), 64'h2345);
    check("wrap_a_ovf", 64'(out_ovf), 64'd1);
    step(1'b1, 32'hFFFF_7FFF, 1'b1, 1'b1, 1'b0, acc);
    check("wrap_b_data", 64'(out_data), 64'h7FFF);
    check("wrap_b_ovf", 64'(out_ovf), 64'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // Backpressure: two beats fill output and skid, then input stalls.
    b[0] = 32'h0000_0011; b[1] = 32'h7FFF_FFFF; b[2] = 32'hFFFF_FFFE; b[3] = 32'h0002_0005;
    step(1'b1, b[0], 1'b0, 1'b0, 1'b0, acc);
    check("bp_acc0", 64'(acc), 64'd1);
    step(1'b1, b[1], 1'b0, 1'b0, 1'b0, acc);
    check("bp_acc1", 64'(acc), 64'd1);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    step(1'b1, b[2], 1'b0, 1'b0, 1'b0, acc);
    check("bp_stall_no_acc", 64'(acc), 64'd0);
    check("bp_hold_data", 64'(out_data), 64'h0011);
    sent = 2;
    for (int i = 0; i < 4; i++) begin
      check("bp_no_gap", 64'(out_valid), 64'd1);
      if (sent < 4) step(1'b1, b[sent], 1'b1, 1'b1, 1'b0, acc);
      else          step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
      if (acc) sent++;
    end
    check("bp_all_sent", 64'(sent), 64'd4);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Counter saturation with a continuous overflow stream.
    for (int i = 0; i < 65536 + 3; i++) begin
      x = 32'h0001_0000 | $urandom;
      step(1'b1, x, 1'($urandom_range(0, 1)), 1'b1, 1'b0, acc);
      if (!acc) check("stream_accept", 64'(acc), 64'd1);
    end
    check("count_saturated", 64'(ovf_count), 64'hFFFF);
    step(1'b1, 32'h4000_0000, 1'b0, 1'b1, 1'b1, acc);
    check("clear_with_ovf_count", 64'(ovf_count), 64'd1);
    check("clear_with_ovf_sticky", 64'(ovf_sticky), 64'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, acc);
    check("clear_alone_count", 64'(ovf_count), 64'd0);

    // Reset during a stall drops everything held.
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h8765_4321, 1'b0, 1'b0, 1'b0, acc);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_out_ovf", 64'(out_ovf), 64'd0);
    check("mid_rst_sticky", 64'(ovf_sticky), 64'd0);
    check("mid_rst_count", 64'(ovf_count), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    m_count = 16'd0; m_sticky = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
    check("post_rst_no_replay", 64'(out_valid), 64'd0);

    // Round trip of sign-extended 15-bit values.
    for (int i = 0; i < 10000; i++) begin
      x = 32'($signed(15'($urandom)));
      step(1'b1, x, 1'($urandom_range(0, 1)), 1'b1, 1'b0, acc);
      if (!acc) check("rt_accept", 64'(acc), 64'd1);
    end

    // Random mix of valid, ready, mode and clear.
    for (int i = 0; i < 2000; i++) begin
      x = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(15'($urandom)));
      step(1'($urandom_range(0, 1)), x, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), acc);
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
      budget++;
    end
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
